// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port, plus per-register
// pending-write counters that let the issue stage detect RAW hazards.
module wb_arbiter #(
    parameter int CNT_W = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        busy_1,
    output logic        busy_2,
    output logic        write_flag,
    output logic [4:0]  reg_write,
    output logic [31:0] write_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Handshake: a transfer happens on a cycle where valid && ready. Each ready
    // is a function of the valids, prio and rdy_in only, never of any ready.
    logic             prio;
    logic             wf_q;
    logic [CNT_W-1:0] cnt [32];
    logic             grant_ex;
    logic             grant_mem;
    logic             issue_fire;
    logic             retire;
    logic [31:0]      inc_vec;
    logic [31:0]      dec_vec;

    always_comb begin
        grant_ex  = rdy_in && ex_valid  && !(mem_valid && prio);
        grant_mem = rdy_in && mem_valid && !(ex_valid && !prio);
    end

    assign ex_ready  = grant_ex;
    assign mem_ready = grant_mem;

    // A registered write held across a stall is deferred, not lost, so its
    // retire still lands once rdy_in returns.
    assign write_flag = wf_q && rdy_in;
    assign retire     = write_flag && (reg_write != 5'd0);

    assign issue_ready = rdy_in && ((issue_rd == 5'd0) ||
                                    (cnt[issue_rd] != CNT_MAX) ||
                                    (write_flag && (reg_write == issue_rd)));
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

    // The register file bypasses write_data, so a last pending write that is
    // being written this cycle no longer counts as a hazard.
    always_comb begin
        busy_1 = (rs1 != 5'd0) && (cnt[rs1] != '0) &&
                 !(write_flag && (reg_write == rs1) && (cnt[rs1] == CNT_ONE));
        busy_2 = (rs2 != 5'd0) && (cnt[rs2] != '0) &&
                 !(write_flag && (reg_write == rs2) && (cnt[rs2] == CNT_ONE));
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_fire) inc_vec[issue_rd]  = 1'b1;
        if (retire)     dec_vec[reg_write] = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prio       <= 1'b0;
            wf_q       <= 1'b0;
            reg_write  <= 5'd0;
            write_data <= 32'd0;
        end else if (rdy_in) begin
            if (grant_ex) begin
                prio <= 1'b1;
                wf_q <= (ex_rd != 5'd0);
                if (ex_rd != 5'd0) begin
                    reg_write  <= ex_rd;
                    write_data <= ex_data;
                end
            end else if (grant_mem) begin
                prio <= 1'b0;
                wf_q <= (mem_rd != 5'd0);
                if (mem_rd != 5'd0) begin
                    reg_write  <= mem_rd;
                    write_data <= mem_data;
                end
            end else begin
                wf_q <= 1'b0;
            end
        end
    end

    // inc_vec[0]/dec_vec[0] are never set, so cnt[0] stays zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else if (rdy_in) begin
            for (int r = 0; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration and scoreboard rules.
module tb_wb_arbiter;

  localparam int CNT_W = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_data = '0;
  logic        ex_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        busy_1;
  logic        busy_2;
  logic        write_flag;
  logic [4:0]  reg_write;
  logic [31:0] write_data;

  wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .busy_1(busy_1), .busy_2(busy_2),
    .write_flag(write_flag), .reg_write(reg_write), .write_data(write_data)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_prio;
  bit          m_wf;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          m_cnt [32];
  bit          e_exr, e_memr, e_ir, e_b1, e_b2, e_wf;
  logic [36:0] exp_q [$];

  function automatic void model_reset();
    m_prio = 1'b0;
    m_wf   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    exp_q.delete();
  endfunction

  function automatic void model_eval();
    e_wf   = rdy_in && m_wf;
    e_exr  = 1'b0;
    e_memr = 1'b0;
    if (rdy_in) begin
      if (ex_valid && mem_valid) begin
        if (m_prio) e_memr = 1'b1;
        else        e_exr  = 1'b1;
      end else if (ex_valid) begin
        e_exr = 1'b1;
      end else if (mem_valid) begin
        e_memr = 1'b1;
      end
    end
    e_ir = rdy_in && (issue_rd == 0 || m_cnt[issue_rd] < MAX || (e_wf && m_wr == issue_rd));
    e_b1 = (rs1 != 0) && (m_cnt[rs1] > 0) && !(e_wf && m_wr == rs1 && m_cnt[rs1] == 1);
    e_b2 = (rs2 != 0) && (m_cnt[rs2] > 0) && !(e_wf && m_wr == rs2 && m_cnt[rs2] == 1);
  endfunction

  // one clock edge: model follows the same inputs the DUT samples
  task automatic advance();
    int ri;
    int ii;
    @(posedge clk_in);
    model_eval();
    if (rdy_in) begin
      ri = (e_wf && m_wr != 0) ? int'(m_wr) : -1;
      ii = (issue_valid && e_ir && issue_rd != 0) ? int'(issue_rd) : -1;
      if (!(ii >= 0 && ii == ri)) begin
        if (ii >= 0) m_cnt[ii]++;
        if (ri >= 0 && m_cnt[ri] > 0) m_cnt[ri]--;
      end
      if (e_exr) begin
        m_prio = 1'b1;
        m_wf   = (ex_rd != 0);
        if (ex_rd != 0) begin
          m_wr = ex_rd;
          m_wd = ex_data;
          exp_q.push_back({ex_rd, ex_data});
        end
      end else if (e_memr) begin
        m_prio = 1'b0;
        m_wf   = (mem_rd != 0);
        if (mem_rd != 0) begin
          m_wr = mem_rd;
          m_wd = mem_data;
          exp_q.push_back({mem_rd, mem_data});
        end
      end else begin
        m_wf = 1'b0;
      end
    end
    #1;
  endtask

  // driver tasks
  task automatic set_idle();
    rdy_in = 1'b1; ex_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    ex_rd = '0; mem_rd = '0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_in = 1'b1;
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_in = 1'b1;
    model_reset();
    #2;
    checks++; if (write_flag !== 1'b0) begin failures++; $display("FAIL reset_write_flag got=%b exp=0", write_flag); end
    checks++; if (reg_write !== 5'd0) begin failures++; $display("FAIL reset_reg_write got=%0d exp=0", reg_write); end
    checks++; if (write_data !== 32'd0) begin failures++; $display("FAIL reset_write_data got=%h exp=0", write_data); end
    checks++; if ({busy_1, busy_2} !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", {busy_1, busy_2}); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
    @(negedge clk_in);
    checks++; if ({ex_ready, mem_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {ex_ready, mem_ready}); end
    advance();
    ex_valid = 1'b0;
    @(negedge clk_in);
    checks++; if (write_flag !== 1'b1) begin failures++; $display("FAIL single_write_flag got=%b exp=1", write_flag); end
    checks++; if (reg_write !== 5'd5) begin failures++; $display("FAIL single_reg_write got=%0d exp=5", reg_write); end
    checks++; if (write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_write_data got=%h exp=deadbeef", write_data); end
    advance();
    @(negedge clk_in);
    checks++; if (write_flag !== 1'b0) begin failures++; $display("FAIL single_write_flag_after got=%b exp=0", write_flag); end
  endtask

  task automatic test_contention();
    do_reset();
    ex_valid = 1'b1;  ex_rd = 5'd1;  ex_data = 32'h1111_0001;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2222_0002;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      checks++;
      if ({ex_ready, mem_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL contention_grant cycle=%0d got=%b exp=%b", c, {ex_ready, mem_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (c > 0) begin
        checks++;
        if (reg_write !== ((c % 2 == 1) ? 5'd1 : 5'd2)) begin
          failures++; $display("FAIL contention_reg_write cycle=%0d got=%0d exp=%0d", c, reg_write, (c % 2 == 1) ? 1 : 2);
        end
      end
      advance();
    end
    set_idle();
    advance();
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk_in);
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_issue_ready got=%b exp=1", issue_ready); end
    advance();
    issue_valid = 1'b0; rs1 = 5'd7;
    @(negedge clk_in);
    checks++; if (busy_1 !== 1'b1) begin failures++; $display("FAIL sb_busy_after_issue got=%b exp=1", busy_1); end
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h0000_0777;
    #1;
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL sb_ex_ready got=%b exp=1", ex_ready); end
    advance();
    ex_valid = 1'b0;
    @(negedge clk_in);
    checks++; if ({write_flag, busy_1} !== 2'b10) begin failures++; $display("FAIL sb_bypass got=%b exp=10", {write_flag, busy_1}); end
    advance();
    @(negedge clk_in);
    checks++; if ({write_flag, busy_1} !== 2'b00) begin failures++; $display("FAIL sb_cleared got=%b exp=00", {write_flag, busy_1}); end
  endtask

  task automatic test_saturation();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
    for (int k = 0; k < MAX; k++) begin
      @(negedge clk_in);
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sat_issue_ready k=%0d got=%b exp=1", k, issue_ready); end
      advance();
    end
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h3333_3333;
    @(negedge clk_in);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sat_full got=%b exp=0", issue_ready); end
    advance();
    ex_valid = 1'b0;
    @(negedge clk_in);
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sat_retire_same_cycle got=%b exp=1", issue_ready); end
    advance();
    @(negedge clk_in);
    checks++; if ({issue_ready, busy_1} !== 2'b01) begin failures++; $display("FAIL sat_count_held got=%b exp=01", {issue_ready, busy_1}); end
    set_idle();
  endtask

  task automatic test_x0();
    do_reset();
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hCAFE_0000;
    @(negedge clk_in);
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL x0_ex_ready got=%b exp=1", ex_ready); end
    advance();
    ex_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    @(negedge clk_in);
    checks++; if (write_flag !== 1'b0) begin failures++; $display("FAIL x0_write_flag got=%b exp=0", write_flag); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL x0_issue_ready got=%b exp=1", issue_ready); end
    advance();
    issue_valid = 1'b0;
    @(negedge clk_in);
    checks++; if (busy_1 !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", busy_1); end
  endtask

  task automatic test_stall();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    advance();
    issue_valid = 1'b0; ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'h0101_0101;
    advance();
    ex_valid = 1'b0;
    advance();
    rs1 = 5'd9; rdy_in = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'h4444_0004;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h6666_0006;
    issue_valid = 1'b1; issue_rd = 5'd10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      checks++;
      if ({ex_ready, mem_ready, issue_ready, write_flag, busy_1} !== 5'b00001) begin
        failures++; $display("FAIL stall_outputs k=%0d got=%b exp=00001", k, {ex_ready, mem_ready, issue_ready, write_flag, busy_1});
      end
      advance();
    end
    rdy_in = 1'b1; issue_valid = 1'b0;
    @(negedge clk_in);
    checks++; if ({ex_ready, mem_ready} !== 2'b01) begin failures++; $display("FAIL stall_resume_prio got=%b exp=01", {ex_ready, mem_ready}); end
    advance();
    set_idle();
    @(negedge clk_in);
    checks++; if ({write_flag, reg_write} !== {1'b1, 5'd6}) begin failures++; $display("FAIL stall_resume_write got=%b/%0d exp=1/6", write_flag, reg_write); end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd12;
    ex_valid = 1'b1; ex_rd = 5'd13; ex_data = 32'h1313_1313;
    advance();
    set_idle();
    rs1 = 5'd12;
    #1;
    checks++; if ({write_flag, busy_1} !== 2'b11) begin failures++; $display("FAIL midreset_before got=%b exp=11", {write_flag, busy_1}); end
    rst_in = 1'b1;
    model_reset();
    #1;
    checks++; if ({write_flag, busy_1} !== 2'b00) begin failures++; $display("FAIL midreset_after got=%b exp=00", {write_flag, busy_1}); end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic test_random();
    logic [36:0] got;
    logic [36:0] exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ex_valid    = ($urandom_range(0, 2) != 0);
      ex_rd       = 5'($urandom_range(0, 4));
      ex_data     = $urandom;
      mem_valid   = ($urandom_range(0, 2) != 0);
      mem_rd      = 5'($urandom_range(0, 4));
      mem_data    = $urandom;
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 4));
      rs1         = 5'($urandom_range(0, 5));
      rs2         = 5'($urandom_range(0, 5));
      @(negedge clk_in);
      model_eval();
      checks++;
      if ({ex_ready, mem_ready, issue_ready} !== {e_exr, e_memr, e_ir}) begin
        failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, {ex_ready, mem_ready, issue_ready}, {e_exr, e_memr, e_ir});
      end
      checks++;
      if ({busy_1, busy_2} !== {e_b1, e_b2}) begin
        failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, {busy_1, busy_2}, {e_b1, e_b2});
      end
      checks++;
      if (write_flag !== e_wf) begin
        failures++; $display("FAIL rand_write_flag n=%0d got=%b exp=%b", n, write_flag, e_wf);
      end
      if (e_wf) begin
        got = {reg_write, write_data};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL rand_write n=%0d got=%0d:%h exp=%0d:%h", n, got[36:32], got[31:0], exp[36:32], exp[31:0]);
        end
      end
      advance();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_scoreboard();
    test_saturation();
    test_x0();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
